// File: rtl/sm_reg_viewer.sv
`default_nettype none
// ============================================================================
//  Module   : sm_reg_viewer
//  Purpose  : Board-level register viewer for the schoolMIPS debug path.
//             Picks a register address (manual switches or timed auto-scan),
//             drives it to the core, captures the returned data and renders
//             it on DIGITS seven-segment digits, paging through wide data.
//  Ports    : clk      - system clock
//             rst      - synchronous reset, active-high
//             mode     - raw switch, 0 = manual address, 1 = auto-scan
//             swAddr   - manual address from switches
//             btnNext  - raw key, steps the address in auto mode
//             btnPage  - raw key, advances the display page
//             regAddr  - address to the core register file
//             regData  - register contents returned for regAddr
//             page     - current display page (for LEDs)
//             hexSeg   - segments, digit i at [i*7+:7], active-low gfedcba
//  Revision : 1.0 - initial release
// ============================================================================
module sm_reg_viewer #(
    parameter  int DIGITS   = 6,
    parameter  int ADDR_W   = 5,
    parameter  int DATA_W   = 32,
    parameter  int SCAN_DIV = 24,
    parameter  int DEB_W    = 16,
    localparam int c_pages  = (DATA_W + 4*DIGITS - 1) / (4*DIGITS),
    localparam int c_page_w = (c_pages > 1) ? $clog2(c_pages) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic [ADDR_W-1:0]   swAddr,
    input  logic                btnNext,
    input  logic                btnPage,
    output logic [ADDR_W-1:0]   regAddr,
    input  logic [DATA_W-1:0]   regData,
    output logic [c_page_w-1:0] page,
    output logic [DIGITS*7-1:0] hexSeg
);

    localparam int                c_nch      = 3;
    // Channel order: 0 = mode, 1 = btnNext, 2 = btnPage.
    // Keys start disarmed so a key held through reset never counts as a
    // press; the mode switch is a level and is honoured straight away.
    localparam logic [c_nch-1:0]  c_arm_init = 3'b001;
    localparam logic [DEB_W-1:0]  c_deb_max  = '1;
    localparam logic [SCAN_DIV-1:0] c_tmr_max = '1;
    localparam int                c_pad_w    = c_pages * DIGITS * 4;

    logic [c_nch-1:0] w_raw;
    logic [c_nch-1:0] w_pulse;
    logic             w_mode_lvl;

    assign w_raw = {btnPage, btnNext, mode};

    // ------------------------------------------------------------------
    // Synchronizer + debouncer per input
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < c_nch; gi++) begin : g_deb
            logic             r_s1, r_s2, r_lvl, r_pls, r_arm;
            logic [DEB_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1  <= 1'b0;
                    r_s2  <= 1'b0;
                    r_lvl <= 1'b0;
                    r_pls <= 1'b0;
                    r_arm <= c_arm_init[gi];
                    r_cnt <= '0;
                end else begin
                    r_s1  <= w_raw[gi];
                    r_s2  <= r_s1;
                    r_pls <= 1'b0;
                    if (!r_arm) begin
                        // Wait for the key to be seen stably released.
                        if (r_s2) begin
                            r_cnt <= '0;
                        end else if (r_cnt == c_deb_max) begin
                            r_arm <= 1'b1;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (r_s2 == r_lvl) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_deb_max) begin
                        r_lvl <= r_s2;
                        r_pls <= r_s2;      // rising edges only
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_pulse[gi] = r_pls;

            if (gi == 0) begin : g_mode_lvl
                assign w_mode_lvl = r_lvl;
            end
        end
    endgenerate

    logic w_mode_rise, w_next_press, w_page_press;
    assign w_mode_rise  = w_pulse[0];
    assign w_next_press = w_pulse[1];
    assign w_page_press = w_pulse[2];

    // ------------------------------------------------------------------
    // Address selection and auto-scan
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]   r_scan_addr;
    logic [SCAN_DIV-1:0] r_scan_tmr;
    logic [ADDR_W-1:0]   r_reg_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_addr <= '0;
            r_scan_tmr  <= '0;
            r_reg_addr  <= '0;
        end else begin
            if (w_mode_rise) begin
                // Entering auto mode seeds the scan from the switches.
                r_scan_addr <= swAddr;
                r_scan_tmr  <= '0;
            end else if (w_mode_lvl) begin
                if (r_scan_tmr == c_tmr_max || w_next_press) begin
                    r_scan_addr <= r_scan_addr + 1'b1;
                    r_scan_tmr  <= '0;
                end else begin
                    r_scan_tmr  <= r_scan_tmr + 1'b1;
                end
            end else begin
                r_scan_tmr <= '0;
            end
            // On the entry cycle the scan address is being loaded with
            // swAddr, so keep showing swAddr rather than the stale value.
            r_reg_addr <= (w_mode_lvl && !w_mode_rise) ? r_scan_addr : swAddr;
        end
    end

    // ------------------------------------------------------------------
    // Page selection
    // ------------------------------------------------------------------
    logic [c_page_w-1:0] r_page;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_page <= '0;
        end else if (w_page_press) begin
            r_page <= (r_page == c_page_w'(c_pages - 1)) ? '0 : r_page + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Data capture and rendering
    // ------------------------------------------------------------------
    function automatic logic [6:0] f_font(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;  4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;  4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;  4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;  4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;  default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    function automatic logic [DIGITS*7-1:0] f_render(input logic [DATA_W-1:0]   d,
                                                      input logic [c_page_w-1:0] pg);
        logic [c_pad_w-1:0]  pad;
        logic [DIGITS*7-1:0] segs;
        int                  n;
        // Zero padding makes a partial top nibble read as zero-extended.
        pad             = '0;
        pad[DATA_W-1:0] = d;
        segs            = '0;
        for (int i = 0; i < DIGITS; i++) begin
            n = int'(pg) * DIGITS + i;
            if (n * 4 >= DATA_W) begin
                segs[i*7 +: 7] = 7'h7F;
            end else begin
                segs[i*7 +: 7] = f_font(pad[n*4 +: 4]);
            end
        end
        return segs;
    endfunction

    logic [DATA_W-1:0]   r_data;
    logic [DIGITS*7-1:0] r_hex;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_hex  <= f_render('0, '0);
        end else begin
            r_data <= regData;
            r_hex  <= f_render(r_data, r_page);
        end
    end

    assign regAddr = r_reg_addr;
    assign page    = r_page;
    assign hexSeg  = r_hex;

endmodule
`default_nettype wire

// File: tb/tb_sm_reg_viewer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sm_reg_viewer
//  Purpose  : Self-checking bench for sm_reg_viewer with a stub register
//             file (reg[k] = 32'h1000_0000 + k, reg[5] overridable).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sm_reg_viewer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [4:0]  swAddr;
    logic        btnNext;
    logic        btnPage;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic [0:0]  page;
    logic [41:0] hexSeg;
    logic        poke5;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        regData = 32'h1000_0000 + {27'd0, regAddr};
        if (poke5 && regAddr == 5'd5) regData = 32'hDEAD_BEEF;
    end

    sm_reg_viewer #(
        .DIGITS  (6),
        .ADDR_W  (5),
        .DATA_W  (32),
        .SCAN_DIV(3),
        .DEB_W   (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .swAddr (swAddr),
        .btnNext(btnNext),
        .btnPage(btnPage),
        .regAddr(regAddr),
        .regData(regData),
        .page   (page),
        .hexSeg (hexSeg)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [41:0] hex;
    } vec_t;

    vec_t tbl [15];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Display with the two low digits given and four leading zeros.
    function automatic logic [41:0] low2(input logic [6:0] d1, input logic [6:0] d0);
        return {{4{7'h40}}, d1, d0};
    endfunction

    localparam logic [41:0] ALL_ZERO = {6{7'h40}};

    initial begin
        tbl[0]  = '{5'h05, low2(7'h40, 7'h12)};
        tbl[1]  = '{5'h09, low2(7'h40, 7'h10)};
        tbl[2]  = '{5'h0A, low2(7'h40, 7'h08)};
        tbl[3]  = '{5'h0B, low2(7'h40, 7'h03)};
        tbl[4]  = '{5'h0C, low2(7'h40, 7'h46)};
        tbl[5]  = '{5'h0D, low2(7'h40, 7'h21)};
        tbl[6]  = '{5'h0E, low2(7'h40, 7'h06)};
        tbl[7]  = '{5'h0F, low2(7'h40, 7'h0E)};
        tbl[8]  = '{5'h12, low2(7'h79, 7'h24)};
        tbl[9]  = '{5'h13, low2(7'h79, 7'h30)};
        tbl[10] = '{5'h14, low2(7'h79, 7'h19)};
        tbl[11] = '{5'h16, low2(7'h79, 7'h02)};
        tbl[12] = '{5'h17, low2(7'h79, 7'h78)};
        tbl[13] = '{5'h18, low2(7'h79, 7'h00)};
        tbl[14] = '{5'h1F, low2(7'h79, 7'h0E)};

        rst = 1'b1; mode = 1'b0; swAddr = 5'd5;
        btnNext = 1'b0; btnPage = 1'b0; poke5 = 1'b0;

        // ---- reset state and first manual address ----
        tick(1);
        chk("rst_regaddr", 64'(regAddr), 64'd0);
        chk("rst_page",    64'(page),    64'd0);
        chk("rst_hex",     64'(hexSeg),  64'(ALL_ZERO));
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("man_addr5_t1", 64'(regAddr), 64'd5);
        tick(2);
        chk("man_hex5_t3", 64'(hexSeg), 64'(low2(7'h40, 7'h12)));
        chk("man_page0",   64'(page),   64'd0);

        // ---- manual-mode vector table ----
        for (int i = 0; i < 15; i++) begin
            swAddr = tbl[i].addr;
            tick(1);
            chk("tbl_regaddr", 64'(regAddr), 64'(tbl[i].addr));
            tick(2);
            chk("tbl_hex", 64'(hexSeg), 64'(tbl[i].hex));
            chk("tbl_page", 64'(page), 64'd0);
        end

        // ---- glitchy btnNext in manual mode, then auto-scan ----
        swAddr = 5'd5;
        tick(3);
        btnNext = 1'b1; tick(1);
        btnNext = 1'b0; tick(1);
        btnNext = 1'b1; tick(1);
        btnNext = 1'b0; tick(10);
        chk("glitch_no_step", 64'(regAddr), 64'd5);
        mode = 1'b1;
        tick(15);
        chk("auto_hold5", 64'(regAddr), 64'd5);
        tick(1);
        chk("auto_step6", 64'(regAddr), 64'd6);
        for (int k = 1; k <= 26; k++) begin
            tick(7);
            chk("auto_before_step", 64'(regAddr), 64'((5 + k) % 32));
            tick(1);
            chk("auto_step", 64'(regAddr), 64'((6 + k) % 32));
        end

        // ---- btnNext press coinciding with terminal count ----
        btnNext = 1'b1;
        tick(7);
        chk("coinc_before", 64'(regAddr), 64'd0);
        tick(1);
        chk("coinc_single_step", 64'(regAddr), 64'd1);
        tick(1);
        btnNext = 1'b0;
        tick(6);
        chk("coinc_next_hold", 64'(regAddr), 64'd1);
        tick(1);
        chk("coinc_next_step", 64'(regAddr), 64'd2);
        // press away from terminal count restarts the timer
        tick(3);
        btnNext = 1'b1;
        tick(5);
        chk("press_tc_step", 64'(regAddr), 64'd3);
        tick(2);
        chk("press_before", 64'(regAddr), 64'd3);
        tick(1);
        chk("press_step", 64'(regAddr), 64'd4);
        btnNext = 1'b0;
        tick(7);
        chk("press_tmr_clr_hold", 64'(regAddr), 64'd4);
        tick(1);
        chk("press_tmr_clr_step", 64'(regAddr), 64'd5);

        // ---- paging at address 3 ----
        mode = 1'b0; swAddr = 5'd3;
        tick(12);
        chk("pg_addr3", 64'(regAddr), 64'd3);
        chk("pg_hex_p0", 64'(hexSeg), 64'(low2(7'h40, 7'h30)));
        btnPage = 1'b1;
        tick(6);
        chk("pg_before", 64'(page), 64'd0);
        tick(1);
        chk("pg_inc", 64'(page), 64'd1);
        chk("pg_hex_lag", 64'(hexSeg), 64'(low2(7'h40, 7'h30)));
        tick(1);
        chk("pg_hex_p1", 64'(hexSeg), 64'({{4{7'h7F}}, 7'h79, 7'h40}));
        btnPage = 1'b0;
        tick(8);
        chk("pg_release", 64'(page), 64'd1);
        btnPage = 1'b1;
        tick(10);
        chk("pg_wrap", 64'(page), 64'd0);
        chk("pg_wrap_hex", 64'(hexSeg), 64'(low2(7'h40, 7'h30)));

        // ---- reset mid-scan with btnPage held ----
        btnPage = 1'b0;
        tick(8);
        swAddr = 5'd20; mode = 1'b1; btnPage = 1'b1;
        tick(10);
        chk("pre_rst_addr", 64'(regAddr), 64'd20);
        chk("pre_rst_page", 64'(page),    64'd1);
        rst = 1'b1;
        tick(2);
        chk("mid_rst_addr", 64'(regAddr), 64'd0);
        chk("mid_rst_page", 64'(page),    64'd0);
        chk("mid_rst_hex",  64'(hexSeg),  64'(ALL_ZERO));
        rst = 1'b0;
        tick(20);
        chk("held_no_page", 64'(page), 64'd0);
        btnPage = 1'b0;
        tick(8);
        chk("released_no_page", 64'(page), 64'd0);
        btnPage = 1'b1;
        tick(6);
        chk("repress_before", 64'(page), 64'd0);
        tick(1);
        chk("repress_page", 64'(page), 64'd1);

        // ---- register contents change under a fixed address ----
        btnPage = 1'b0; mode = 1'b0; swAddr = 5'd5;
        tick(8);
        btnPage = 1'b1;
        tick(10);
        btnPage = 1'b0;
        tick(10);
        chk("poke_page0", 64'(page), 64'd0);
        chk("poke_before", 64'(hexSeg), 64'(low2(7'h40, 7'h12)));
        poke5 = 1'b1;
        tick(1);
        chk("poke_lag", 64'(hexSeg), 64'(low2(7'h40, 7'h12)));
        tick(1);
        chk("poke_hex", 64'(hexSeg), 64'({7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}));
        tick(1);
        chk("poke_hex_stable", 64'(hexSeg), 64'({7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
